inject_pulse_sequencer: RTL and testbench
=========================================

# inject_pulse_sequencer

Programmable pulse-train controller for the pixel-configuration path. It turns a single-cycle start command into N injection/strobe pulses with programmable initial delay, high width and low gap. It replaces fixed-length stretching with software-controlled sequencing. It sits between the configuration register bank (start/cfg fields) and the pixel-array pulse/strobe line, and reports busy/done/progress back to the register bank.

## Interface
- CNT_WIDTH, 16, width of every timing/count field and of the progress counter
- clk_in  input  1  system clock; all logic on rising edge
- rst  input  1  reset, asynchronous, active-high
- start  input  1  single-cycle command; accepted only when busy=0
- cfg_delay  input  CNT_WIDTH  cycles from acceptance to first high cycle
- cfg_high  input  CNT_WIDTH  high width per pulse in cycles; 0 treated as 1
- cfg_low  input  CNT_WIDTH  low gap between pulses in cycles; 0 treated as 1
- cfg_count  input  CNT_WIDTH  number of pulses; 0 = no pulses
- abort  input  1  cancel running sequence (effective only with SEQ_ABORT_EN)
- pulse_out  output  1  registered pulse line to the pixel array
- busy  output  1  sequence in progress
- done  output  1  one-cycle completion strobe
- pulse_idx  output  CNT_WIDTH  pulses completed in current/last sequence

## Operation
- States: IDLE, DELAY, HIGH, LOW, DONE. All outputs registered; pulse_out=1 exactly in HIGH, busy=1 in DELAY/HIGH/LOW, done=1 exactly in DONE.
- Reset: state IDLE; pulse_out=0, busy=0, done=0, pulse_idx=0; shadow config registers cleared.
- Acceptance: start=1 while state is IDLE or DONE. The cfg_* fields are latched into shadow registers on that edge. Later cfg_* changes do not affect the running sequence. pulse_idx is cleared to 0.
- After acceptance:
  - If cfg_count=0, go to DONE; no pulse is produced.
  - Otherwise, if cfg_delay>0, go to DELAY for cfg_delay cycles.
  - Otherwise, go directly to HIGH.
- HIGH lasts max(cfg_high,1) cycles. On its last cycle pulse_idx increments.
  - If pulse_idx+1 equals the count, go to DONE.
  - Otherwise go to LOW.
- LOW lasts max(cfg_low,1) cycles, then HIGH.
- DONE lasts one cycle, then IDLE. If start=1 in DONE, the new sequence is accepted and IDLE is skipped.
- start while busy=1 is ignored; it is not queued.
- Phase counter: a single down-counter, CNT_WIDTH wide, loaded at each phase entry with the phase length minus 1. The phase ends when the counter reaches 0. It never wraps. Full-scale values (2^CNT_WIDTH−1) must work.
- pulse_idx holds its final value until the next acceptance or reset.

## Timing
- Start latency: start sampled high at edge T.
  - busy=1 from cycle T+1.
  - First high cycle is T+1+cfg_delay.
- Single pulse, D/H/L = delay, high, low (after the 0→1 substitution):
  - Pulse k (k=0..N−1) is high in cycles T+1+D+k(H+L) through T+D+k(H+L)+H.
- DONE/done is at cycle T+1+D+N·H+(N−1)·L. busy=0 in that cycle.
- cfg_count=0: done at T+1; busy never asserts.
- Reset asserted mid-sequence: all outputs return to reset values immediately (asynchronously). No done is generated.

## Configuration
- SEQ_ABORT_EN defined:
  - abort=1 sampled while busy=1 forces IDLE on the next edge, with pulse_out=0, busy=0 and done=0.
  - pulse_idx keeps the count of completed pulses.
  - If start and abort are high in the same cycle while busy=0, start wins.
- SEQ_ABORT_EN undefined: the abort port remains but is ignored; sequences always run to DONE.

## Test plan
- cfg D=2,H=3,L=1,N=2, start at cycle 0 → pulse_out high cycles 3–5 and 7–9; done only at cycle 10; busy 1–9; pulse_idx=2.
- D=0,H=0,L=0,N=3 → zero-length fields treated as 1; pulse_out high at 1, 3, 5; done at 6.
- N=0 with any D → done at cycle 1; pulse_out and busy stay 0; pulse_idx=0.
- Start during busy, and cfg changes mid-run → no effect on the running train; start asserted in the DONE cycle → new train begins with busy at the next cycle.
- rst pulse during the second HIGH of an N=4 train → pulse_out, busy and done fall immediately; pulse_idx=0; a subsequent start runs normally.
- With SEQ_ABORT_EN: abort during the third pulse of N=5 → pulse_out=0 and busy=0 next cycle, no done, pulse_idx=2. Without the macro: the same stimulus completes all 5 pulses and done.

Source files
------------

// File: rtl/inject_pulse_sequencer.sv
// ---------------------------------------------------------------------------
// inject_pulse_sequencer
//
// Turns a single-cycle start command into a train of injection/strobe
// pulses for the pixel array. Each train has a programmable initial delay,
// a high width, a low gap and a pulse count. The train timing is captured
// when the command is accepted, so software can reprogram the cfg fields
// while a train is still running.
//
// Optional feature macro: SEQ_ABORT_EN
//   defined   -> abort cancels a running train (back to IDLE, no done)
//   undefined -> abort port is present but has no effect
//
// Ports
//   clk_in     : system clock, all logic on the rising edge
//   rst        : asynchronous, active-high reset
//   start      : single-cycle command, accepted only while not busy
//   cfg_delay  : cycles from acceptance to the first high cycle
//   cfg_high   : high width per pulse in cycles (0 behaves as 1)
//   cfg_low    : low gap between pulses in cycles (0 behaves as 1)
//   cfg_count  : number of pulses (0 = complete with no pulses)
//   abort      : cancel a running train (only with SEQ_ABORT_EN)
//   pulse_out  : registered pulse line to the pixel array
//   busy       : train in progress (DELAY/HIGH/LOW)
//   done       : one-cycle completion strobe
//   pulse_idx  : pulses completed in the current/last train
// ---------------------------------------------------------------------------
module inject_pulse_sequencer #(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk_in,
  input  logic                 rst,
  input  logic                 start,
  input  logic [CNT_WIDTH-1:0] cfg_delay,
  input  logic [CNT_WIDTH-1:0] cfg_high,
  input  logic [CNT_WIDTH-1:0] cfg_low,
  input  logic [CNT_WIDTH-1:0] cfg_count,
  input  logic                 abort,
  output logic                 pulse_out,
  output logic                 busy,
  output logic                 done,
  output logic [CNT_WIDTH-1:0] pulse_idx
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_DELAY = 3'd1,
    S_HIGH  = 3'd2,
    S_LOW   = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [CNT_WIDTH-1:0] ZERO = '0;
  localparam logic [CNT_WIDTH-1:0] ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  // Sequencer state and the single shared phase down-counter
  state_t               r_state;
  logic [CNT_WIDTH-1:0] r_cnt;
  logic [CNT_WIDTH-1:0] r_idx;

  // Shadow copies of the train timing, frozen at acceptance
  logic [CNT_WIDTH-1:0] r_high;
  logic [CNT_WIDTH-1:0] r_low;
  logic [CNT_WIDTH-1:0] r_count;

  // Registered outputs
  logic                 r_pulse;
  logic                 r_busy;
  logic                 r_done;

  // Next-state values
  state_t               w_nextState;
  logic [CNT_WIDTH-1:0] w_nextCnt;
  logic [CNT_WIDTH-1:0] w_nextIdx;
  logic                 w_accept;
  logic                 w_abort;
  logic [CNT_WIDTH-1:0] w_idxInc;

  // Phase length minus one for the counter load. A zero-length field is
  // stretched to one cycle, so both 0 and 1 load 0. Full-scale lengths
  // load all-ones minus one, so the counter never needs to wrap.
  function automatic logic [CNT_WIDTH-1:0] phaseLoad(input logic [CNT_WIDTH-1:0] len);
    return (len == ZERO) ? ZERO : (len - ONE);
  endfunction

`ifdef SEQ_ABORT_EN
  assign w_abort = abort;
`else
  // Abort is tied off so sequences always run to DONE.
  assign w_abort = abort & 1'b0;
`endif

  // A new train can start from IDLE or directly from the DONE cycle.
  assign w_accept = start && ((r_state == S_IDLE) || (r_state == S_DONE));
  assign w_idxInc = r_idx + ONE;

  // Next-state logic. Abort has priority over phase progress, so an abort
  // on the final cycle of a high phase does not count that pulse.
  always_comb begin
    w_nextState = r_state;
    w_nextCnt   = r_cnt;
    w_nextIdx   = r_idx;

    case (r_state)
      S_IDLE, S_DONE: begin
        if (w_accept) begin
          w_nextIdx = ZERO;
          if (cfg_count == ZERO) begin
            w_nextState = S_DONE;
            w_nextCnt   = ZERO;
          end else if (cfg_delay != ZERO) begin
            w_nextState = S_DELAY;
            w_nextCnt   = cfg_delay - ONE;
          end else begin
            w_nextState = S_HIGH;
            w_nextCnt   = phaseLoad(cfg_high);
          end
        end else begin
          w_nextState = S_IDLE;
        end
      end

      S_DELAY: begin
        if (w_abort) begin
          w_nextState = S_IDLE;
        end else if (r_cnt == ZERO) begin
          w_nextState = S_HIGH;
          w_nextCnt   = phaseLoad(r_high);
        end else begin
          w_nextCnt   = r_cnt - ONE;
        end
      end

      S_HIGH: begin
        if (w_abort) begin
          w_nextState = S_IDLE;
        end else if (r_cnt == ZERO) begin
          w_nextIdx = w_idxInc;
          if (w_idxInc == r_count) begin
            w_nextState = S_DONE;
            w_nextCnt   = ZERO;
          end else begin
            w_nextState = S_LOW;
            w_nextCnt   = phaseLoad(r_low);
          end
        end else begin
          w_nextCnt   = r_cnt - ONE;
        end
      end

      S_LOW: begin
        if (w_abort) begin
          w_nextState = S_IDLE;
        end else if (r_cnt == ZERO) begin
          w_nextState = S_HIGH;
          w_nextCnt   = phaseLoad(r_high);
        end else begin
          w_nextCnt   = r_cnt - ONE;
        end
      end

      default: begin
        w_nextState = S_IDLE;
        w_nextCnt   = ZERO;
      end
    endcase
  end

  // State, counter, shadow and output registers. Outputs are decoded from
  // the next state so they line up exactly with the state they describe.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= ZERO;
      r_idx   <= ZERO;
      r_high  <= ZERO;
      r_low   <= ZERO;
      r_count <= ZERO;
      r_pulse <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_nextState;
      r_cnt   <= w_nextCnt;
      r_idx   <= w_nextIdx;
      r_pulse <= (w_nextState == S_HIGH);
      r_busy  <= (w_nextState == S_DELAY) || (w_nextState == S_HIGH) ||
                 (w_nextState == S_LOW);
      r_done  <= (w_nextState == S_DONE);
      if (w_accept) begin
        r_high  <= cfg_high;
        r_low   <= cfg_low;
        r_count <= cfg_count;
      end
    end
  end

  assign pulse_out = r_pulse;
  assign busy      = r_busy;
  assign done      = r_done;
  assign pulse_idx = r_idx;

endmodule

// File: tb/tb_inject_pulse_sequencer.sv
// ---------------------------------------------------------------------------
// tb_inject_pulse_sequencer
//
// Self-checking bench for inject_pulse_sequencer. A timeline model derives
// every output for any cycle from the accepted train's start cycle and its
// delay/high/low/count, and is compared against the DUT every cycle.
// Directed scenarios add hand-computed literal expectations.
// Honours SEQ_ABORT_EN the same way the design does.
// ---------------------------------------------------------------------------
module tb_inject_pulse_sequencer;

`ifdef SEQ_ABORT_EN
  localparam bit ABORT_EN = 1'b1;
`else
  localparam bit ABORT_EN = 1'b0;
`endif

  logic        clk_in;
  logic        rst;
  logic        start;
  logic [15:0] cfg_delay;
  logic [15:0] cfg_high;
  logic [15:0] cfg_low;
  logic [15:0] cfg_count;
  logic        abort;
  logic        pulse_out;
  logic        busy;
  logic        done;
  logic [15:0] pulse_idx;

  int     checks   = 0;
  int     failures = 0;
  longint cyc      = 0;

  // Model of the currently accepted train
  bit     mHas   = 1'b0;
  longint mT     = 0;
  longint mD     = 0;
  longint mH     = 1;
  longint mL     = 1;
  longint mN     = 0;
  longint mAbort = -1;

  inject_pulse_sequencer #(.CNT_WIDTH(16)) dut (
    .clk_in    (clk_in),
    .rst       (rst),
    .start     (start),
    .cfg_delay (cfg_delay),
    .cfg_high  (cfg_high),
    .cfg_low   (cfg_low),
    .cfg_count (cfg_count),
    .abort     (abort),
    .pulse_out (pulse_out),
    .busy      (busy),
    .done      (done),
    .pulse_idx (pulse_idx)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  always @(posedge clk_in) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input longint actual, input longint expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("[TB] FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, actual, expected);
    end
  endtask

  // Train outputs for cycle c, ignoring abort
  function automatic void rawAt(input longint c, output bit p, output bit b,
                                output bit d, output longint idx);
    longint endC, rel, per, k, off;
    p = 0; b = 0; d = 0; idx = 0;
    if (mN == 0) begin
      d = (c == mT + 1);
    end else begin
      endC = mT + 1 + mD + mN * mH + (mN - 1) * mL;
      if (c < endC) begin
        b   = 1;
        rel = c - (mT + 1 + mD);
        if (rel >= 0) begin
          per = mH + mL;
          k   = rel / per;
          off = rel % per;
          p   = (off < mH);
          idx = k + ((off >= mH) ? 1 : 0);
        end
      end else begin
        d   = (c == endC);
        idx = mN;
      end
    end
  endfunction

  function automatic void modelAt(input longint c, output bit p, output bit b,
                                  output bit d, output longint idx);
    p = 0; b = 0; d = 0; idx = 0;
    if (mHas) begin
      if (mAbort >= 0 && c > mAbort) begin
        rawAt(mAbort, p, b, d, idx);
        p = 0; b = 0; d = 0;
      end else begin
        rawAt(c, p, b, d, idx);
      end
    end
  endfunction

  // Every-cycle compare, then the model absorbs this cycle's inputs
  always @(negedge clk_in) begin
    bit     ep, eb, ed;
    longint ei;
    if (rst) begin
      mHas = 1'b0;
      checkOutput("cmp_rst_pulse", pulse_out, 0);
      checkOutput("cmp_rst_busy",  busy,      0);
      checkOutput("cmp_rst_done",  done,      0);
      checkOutput("cmp_rst_idx",   pulse_idx, 0);
    end else begin
      modelAt(cyc, ep, eb, ed, ei);
      checkOutput("cmp_pulse", pulse_out, ep);
      checkOutput("cmp_busy",  busy,      eb);
      checkOutput("cmp_done",  done,      ed);
      checkOutput("cmp_idx",   pulse_idx, ei);
      if (start && !eb) begin
        mHas   = 1'b1;
        mT     = cyc;
        mD     = cfg_delay;
        mH     = (cfg_high == 0) ? 1 : cfg_high;
        mL     = (cfg_low  == 0) ? 1 : cfg_low;
        mN     = cfg_count;
        mAbort = -1;
      end else if (abort && eb && ABORT_EN && mAbort < 0) begin
        mAbort = cyc;
      end
    end
  end

  // Drive one start cycle; called just after a rising edge, returns one
  // cycle later with t holding the cycle in which start was high.
  task automatic applyStimulus(input logic [15:0] d, input logic [15:0] h,
                               input logic [15:0] l, input logic [15:0] n,
                               output longint t);
    t         = cyc;
    cfg_delay = d;
    cfg_high  = h;
    cfg_low   = l;
    cfg_count = n;
    start     = 1'b1;
    @(posedge clk_in); #1;
    start     = 1'b0;
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(posedge clk_in);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    longint      t;
    logic [11:0] expP;
    logic [11:0] expB;
    logic [11:0] expD;

    rst = 1'b1; start = 1'b0; abort = 1'b0;
    cfg_delay = '0; cfg_high = '0; cfg_low = '0; cfg_count = '0;
    #1;
    checkOutput("reset_pulse", pulse_out, 0);
    checkOutput("reset_busy",  busy,      0);
    checkOutput("reset_done",  done,      0);
    checkOutput("reset_idx",   pulse_idx, 0);
    waitCycles(3);
    rst = 1'b0;
    waitCycles(1);

    // D=2 H=3 L=1 N=2: high 3-5 and 7-9, busy 1-9, done 10
    $display("[TB] train D=2 H=3 L=1 N=2");
    expP = 12'h3B8; expB = 12'h3FE; expD = 12'h400;
    applyStimulus(16'd2, 16'd3, 16'd1, 16'd2, t);
    for (int r = 1; r <= 11; r++) begin
      @(negedge clk_in);
      checkOutput("t1_pulse", pulse_out, expP[r]);
      checkOutput("t1_busy",  busy,      expB[r]);
      checkOutput("t1_done",  done,      expD[r]);
    end
    checkOutput("t1_idx", pulse_idx, 2);
    waitCycles(2);

    // Zero-length fields behave as 1: high 1,3,5, done 6
    $display("[TB] train D=0 H=0 L=0 N=3");
    expP = 12'h02A; expD = 12'h040;
    applyStimulus(16'd0, 16'd0, 16'd0, 16'd3, t);
    for (int r = 1; r <= 7; r++) begin
      @(negedge clk_in);
      checkOutput("t2_pulse", pulse_out, expP[r]);
      checkOutput("t2_done",  done,      expD[r]);
    end
    checkOutput("t2_idx", pulse_idx, 3);
    waitCycles(2);

    // N=0: done at cycle 1, nothing else
    $display("[TB] train N=0");
    applyStimulus(16'd5, 16'd2, 16'd2, 16'd0, t);
    @(negedge clk_in);
    checkOutput("t3_done1", done,      1);
    checkOutput("t3_busy1", busy,      0);
    checkOutput("t3_pulse", pulse_out, 0);
    @(negedge clk_in);
    checkOutput("t3_done2", done,      0);
    checkOutput("t3_idx",   pulse_idx, 0);
    waitCycles(2);

    // Start while busy and cfg changes ignored; restart in the DONE cycle
    $display("[TB] busy start / cfg change / restart from DONE");
    applyStimulus(16'd1, 16'd2, 16'd2, 16'd3, t);
    waitCycles(2);
    cfg_delay = 16'd0; cfg_high = 16'd5; cfg_low = 16'd5; cfg_count = 16'd7;
    start = 1'b1;
    waitCycles(1);
    start = 1'b0;
    waitCycles(8);
    checkOutput("t4_done_cycle", done,      1);
    checkOutput("t4_idx",        pulse_idx, 3);
    applyStimulus(16'd0, 16'd1, 16'd1, 16'd1, t);
    checkOutput("t4_restart_busy",  busy,      1);
    checkOutput("t4_restart_pulse", pulse_out, 1);
    waitCycles(4);

    // Reset in the second high phase of an N=4 train
    $display("[TB] reset mid-train");
    applyStimulus(16'd0, 16'd3, 16'd2, 16'd4, t);
    waitCycles(6);
    checkOutput("t5_pre_pulse", pulse_out, 1);
    checkOutput("t5_pre_idx",   pulse_idx, 1);
    rst = 1'b1;
    #1;
    checkOutput("t5_rst_pulse", pulse_out, 0);
    checkOutput("t5_rst_busy",  busy,      0);
    checkOutput("t5_rst_done",  done,      0);
    checkOutput("t5_rst_idx",   pulse_idx, 0);
    @(negedge clk_in); #1;
    rst = 1'b0;
    waitCycles(1);
    applyStimulus(16'd1, 16'd1, 16'd1, 16'd2, t);
    waitCycles(8);
    checkOutput("t5_after_idx", pulse_idx, 2);

    // Abort in the third pulse of N=5; abort also high at the start cycle
    $display("[TB] abort during third pulse");
    abort = 1'b1;
    applyStimulus(16'd0, 16'd2, 16'd2, 16'd5, t);
    abort = 1'b0;
    checkOutput("t6_start_wins", busy, 1);
    waitCycles(8);
    abort = 1'b1;
    waitCycles(1);
    abort = 1'b0;
    checkOutput("t6_busy_next", busy, ABORT_EN ? 0 : 1);
    waitCycles(12);
    checkOutput("t6_idx", pulse_idx, ABORT_EN ? 2 : 5);

    // Full-scale delay
    $display("[TB] full-scale delay");
    applyStimulus(16'hFFFF, 16'd1, 16'd1, 16'd1, t);
    waitCycles(65534);
    checkOutput("t7_still_delay", pulse_out, 0);
    waitCycles(1);
    checkOutput("t7_high", pulse_out, 1);
    waitCycles(1);
    checkOutput("t7_done", done,      1);
    checkOutput("t7_idx",  pulse_idx, 1);
    waitCycles(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
